// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;

   localparam int ARB_ADDR_WIDTH = 32;
   localparam int ARB_DATA_WIDTH = 32;
   localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;

   typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D} arb_state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

   typedef struct packed {
      logic                      req;
      logic [ARB_ADDR_WIDTH-1:0] addr;
   } if_req_t;

   typedef struct packed {
      logic                      req;
      logic                      we;
      logic [ARB_ADDR_WIDTH-1:0] addr;
      logic [ARB_DATA_WIDTH-1:0] wdata;
      logic [ARB_BE_WIDTH-1:0]   be;
   } d_req_t;

   typedef struct packed {
      logic                      we;
      logic [ARB_ADDR_WIDTH-1:0] addr;
      logic [ARB_DATA_WIDTH-1:0] wdata;
      logic [ARB_BE_WIDTH-1:0]   be;
   } mem_cmd_t;

   // Fetches are always full-word reads.
   function automatic mem_cmd_t fetch_cmd(input logic [ARB_ADDR_WIDTH-1:0] addr);
      mem_cmd_t c;
      c.we    = 1'b0;
      c.addr  = addr;
      c.wdata = '0;
      c.be    = '1;
      return c;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data stages
// Data has priority; a streak counter forces a fetch after MAX_DATA_STREAK data wins.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH      = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH      = ARB_DATA_WIDTH,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   input  logic                    if_flush,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   arb_state_e    state_q, state_d;
   owner_e        lock_q, lock_d;
   owner_e        owner;
   logic          discard_q, discard_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          window;
   if_req_t       if_r;
   d_req_t        d_r;
   mem_cmd_t      cmd;

   always_comb begin
      if_r = '{req: if_req, addr: if_addr};
      d_r  = '{req: d_req, we: d_we, addr: d_addr, wdata: d_wdata, be: d_be};

      // A returning response frees the port in the same cycle.
      window = (state_q == ARB_IDLE) || mem_rvalid;

      owner = OWN_NONE;
      if (lock_q != OWN_NONE)
         owner = lock_q;
      else if (if_r.req && d_r.req)
         owner = (streak_q == STREAK_MAX) ? OWN_IF : OWN_D;
      else if (if_r.req)
         owner = OWN_IF;
      else if (d_r.req)
         owner = OWN_D;

      cmd = '0;
      case (owner)
         OWN_IF:  cmd = fetch_cmd(if_r.addr);
         OWN_D:   cmd = '{we: d_r.we, addr: d_r.addr, wdata: d_r.wdata, be: d_r.be};
         default: cmd = '0;
      endcase

      mem_req   = window && (owner != OWN_NONE) && !arst;
      mem_we    = cmd.we;
      mem_addr  = cmd.addr;
      mem_wdata = cmd.wdata;
      mem_be    = cmd.be;
      if_gnt    = mem_req && mem_gnt && (owner == OWN_IF);
      d_gnt     = mem_req && mem_gnt && (owner == OWN_D);

      if_rvalid = mem_rvalid && (state_q == ARB_WAIT_I) && !discard_q && !if_flush;
      d_rvalid  = mem_rvalid && (state_q == ARB_WAIT_D);

      lock_d = (mem_req && !mem_gnt) ? owner : OWN_NONE;

      state_d = state_q;
      if (mem_req && mem_gnt)
         state_d = (owner == OWN_IF) ? ARB_WAIT_I : ARB_WAIT_D;
      else if ((state_q != ARB_IDLE) && mem_rvalid)
         state_d = ARB_IDLE;

      // A flush against a fetch still stuck in lock marks its future response stale too.
      discard_d = discard_q;
      if ((state_q == ARB_WAIT_I) && mem_rvalid)
         discard_d = 1'b0;
      else if (if_flush && (state_q == ARB_WAIT_I))
         discard_d = 1'b1;
      else if (if_flush && mem_req && (lock_q == OWN_IF))
         discard_d = 1'b1;

      streak_d = streak_q;
      if (if_gnt || !if_req)
         streak_d = '0;
      else if (d_gnt && (streak_q != STREAK_MAX))
         streak_d = streak_q + SW'(1);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= ARB_IDLE;
         lock_q    <= OWN_NONE;
         discard_q <= 1'b0;
         streak_q  <= '0;
      end else begin
         state_q   <= state_d;
         lock_q    <= lock_d;
         discard_q <= discard_d;
         streak_q  <= streak_d;
      end
   end

   assign if_rdata = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        arst;
   logic        if_req, if_flush, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int tests = 0;
   int fails = 0;
   logic chk_rv_en = 1'b0;
   logic chk_hold_en = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
      .clk(clk), .arst(arst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   assert property (@(posedge clk) disable iff (arst || !chk_rv_en)
                    mem_rvalid |-> (dut.state_q != ARB_IDLE))
      else begin fails++; $display("FAIL assert_rvalid_idle: mem_rvalid with nothing outstanding"); end
   assert property (@(posedge clk) disable iff (arst || !chk_hold_en)
                    (if_req && !if_gnt) |=> if_req)
      else begin fails++; $display("FAIL assert_if_hold: if_req dropped before if_gnt"); end
   assert property (@(posedge clk) disable iff (arst || !chk_hold_en)
                    (d_req && !d_gnt) |=> d_req)
      else begin fails++; $display("FAIL assert_d_hold: d_req dropped before d_gnt"); end

   typedef struct {
      logic        if_req;  logic [31:0] if_addr; logic if_flush;
      logic        d_req;   logic d_we; logic [31:0] d_addr; logic [31:0] d_wdata; logic [3:0] d_be;
      logic        gnt;     logic rv;   logic [31:0] rdata;
      logic        e_mreq;  logic e_we; logic [31:0] e_addr; logic [3:0] e_be;
      logic        e_ig;    logic e_dg; logic e_irv; logic e_drv;
   } vec_t;

   typedef struct { logic is_if; logic [31:0] data; } resp_t;

   vec_t   vecs[$];
   owner_e exp_owner_q[$];
   resp_t  resp_q[$];

   task automatic check(input bit ok, input string name, input string msg);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: %s", name, msg);
      end
   endtask

   task automatic add(input int unsigned ir, ia, fl, dr, dw, da, dd, db, g, rv, rd,
                      em, ew, ea, eb, eig, edg, eirv, edrv);
      vec_t v;
      v.if_req = ir[0]; v.if_addr = ia; v.if_flush = fl[0];
      v.d_req = dr[0]; v.d_we = dw[0]; v.d_addr = da; v.d_wdata = dd; v.d_be = db[3:0];
      v.gnt = g[0]; v.rv = rv[0]; v.rdata = rd;
      v.e_mreq = em[0]; v.e_we = ew[0]; v.e_addr = ea; v.e_be = eb[3:0];
      v.e_ig = eig[0]; v.e_dg = edg[0]; v.e_irv = eirv[0]; v.e_drv = edrv[0];
      vecs.push_back(v);
   endtask

   task automatic drive_idle();
      if_req = 0; if_addr = '0; if_flush = 0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   function automatic logic [31:0] model(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   initial begin
      logic        pend;
      logic [31:0] pend_data, ia, da;
      owner_e      got, exp_o;
      resp_t       r;
      bit          ok;

      // reset with everything asserted on the inputs
      drive_idle();
      arst = 1; if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h20; mem_gnt = 1; mem_rvalid = 1;
      @(negedge clk);
      check({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid} == 5'b0, "reset_outputs",
            $sformatf("got req/ig/dg/irv/drv=%b%b%b%b%b want 00000", mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid));
      @(posedge clk); #1;
      drive_idle();
      arst = 0;
      chk_rv_en = 1; chk_hold_en = 1;

      //  ir  ia      fl  dr dw da     dd             db   g rv rd            em ew ea     eb   ig dg irv drv
      add(1, 'h100, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h100, 'hF, 1, 0, 0, 0);
      add(1, 'h104, 0,  0, 0, 0,     0,             0,   1, 0, 0,            0, 0, 0,     0,   0, 0, 0, 0);
      add(1, 'h104, 0,  0, 0, 0,     0,             0,   1, 1, 'h00500093,   1, 0, 'h104, 'hF, 1, 0, 1, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'h11,         0, 0, 0,     0,   0, 0, 1, 0);
      add(0, 0,     0,  1, 1, 'h80,  'hDEADBEEF,    'h3, 1, 0, 0,            1, 1, 'h80,  'h3, 0, 1, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 0,            0, 0, 0,     0,   0, 0, 0, 1);
      add(0, 0,     0,  1, 0, 'h300, 0,             'hF, 0, 0, 0,            1, 0, 'h300, 'hF, 0, 0, 0, 0);
      add(1, 'h500, 0,  1, 0, 'h300, 0,             'hF, 0, 0, 0,            1, 0, 'h300, 'hF, 0, 0, 0, 0);
      add(1, 'h500, 0,  1, 0, 'h300, 0,             'hF, 0, 0, 0,            1, 0, 'h300, 'hF, 0, 0, 0, 0);
      add(1, 'h500, 0,  1, 0, 'h300, 0,             'hF, 1, 0, 0,            1, 0, 'h300, 'hF, 0, 1, 0, 0);
      add(1, 'h500, 0,  0, 0, 0,     0,             0,   1, 1, 'h33,         1, 0, 'h500, 'hF, 1, 0, 0, 1);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'h44,         0, 0, 0,     0,   0, 0, 1, 0);
      add(1, 'h200, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h200, 'hF, 1, 0, 0, 0);
      add(0, 0,     1,  0, 0, 0,     0,             0,   1, 0, 0,            0, 0, 0,     0,   0, 0, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 0, 0,            0, 0, 0,     0,   0, 0, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'h77,         0, 0, 0,     0,   0, 0, 0, 0);
      add(1, 'h400, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h400, 'hF, 1, 0, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'h99,         0, 0, 0,     0,   0, 0, 1, 0);
      add(1, 'h600, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h600, 'hF, 1, 0, 0, 0);
      add(0, 0,     1,  0, 0, 0,     0,             0,   1, 1, 'hAA,         0, 0, 0,     0,   0, 0, 0, 0);
      add(0, 0,     0,  1, 0, 'h44,  0,             'hF, 1, 0, 0,            1, 0, 'h44,  'hF, 0, 1, 0, 0);
      add(0, 0,     1,  0, 0, 0,     0,             0,   1, 1, 'hBB,         0, 0, 0,     0,   0, 0, 0, 1);
      add(1, 'h700, 0,  0, 0, 0,     0,             0,   0, 0, 0,            1, 0, 'h700, 'hF, 0, 0, 0, 0);
      add(1, 'h700, 1,  0, 0, 0,     0,             0,   0, 0, 0,            1, 0, 'h700, 'hF, 0, 0, 0, 0);
      add(1, 'h700, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h700, 'hF, 1, 0, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'hCC,         0, 0, 0,     0,   0, 0, 0, 0);
      add(1, 'h800, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h800, 'hF, 1, 0, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'hDD,         0, 0, 0,     0,   0, 0, 1, 0);
      add(0, 0,     1,  0, 0, 0,     0,             0,   1, 0, 0,            0, 0, 0,     0,   0, 0, 0, 0);
      add(1, 'h900, 0,  0, 0, 0,     0,             0,   1, 0, 0,            1, 0, 'h900, 'hF, 1, 0, 0, 0);
      add(0, 0,     0,  0, 0, 0,     0,             0,   1, 1, 'hEE,         0, 0, 0,     0,   0, 0, 1, 0);

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         if_req = v.if_req; if_addr = v.if_addr; if_flush = v.if_flush;
         d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_be = v.d_be;
         mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rdata;
         @(negedge clk);
         ok = (mem_req === v.e_mreq) && (if_gnt === v.e_ig) && (d_gnt === v.e_dg) &&
              (if_rvalid === v.e_irv) && (d_rvalid === v.e_drv) &&
              (!v.e_mreq || ((mem_we === v.e_we) && (mem_addr === v.e_addr) && (mem_be === v.e_be))) &&
              (!v.e_mreq || !v.e_we || (mem_wdata === v.d_wdata)) &&
              (!v.e_irv || (if_rdata === v.rdata)) && (!v.e_drv || (d_rdata === v.rdata));
         check(ok, $sformatf("vec%0d", i),
               $sformatf("got req=%b we=%b addr=%h be=%h ig=%b dg=%b irv=%b drv=%b rd=%h/%h want req=%b we=%b addr=%h be=%h ig=%b dg=%b irv=%b drv=%b rd=%h",
                         mem_req, mem_we, mem_addr, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata,
                         v.e_mreq, v.e_we, v.e_addr, v.e_be, v.e_ig, v.e_dg, v.e_irv, v.e_drv, v.rdata));
         @(posedge clk); #1;
      end
      drive_idle();

      // contention: 1-cycle memory, both requesters held
      for (int k = 0; k < 20; k++) exp_owner_q.push_back((k % 5 == 4) ? OWN_IF : OWN_D);
      pend = 0; pend_data = '0; ia = 32'h2000; da = 32'h1000;
      for (int k = 0; k < 20; k++) begin
         if_req = 1; if_addr = ia; d_req = 1; d_we = 0; d_addr = da; d_be = 4'hF;
         mem_gnt = 1; mem_rvalid = pend; mem_rdata = pend_data;
         @(negedge clk);
         if (pend) begin
            r = resp_q.pop_front();
            check((if_rvalid === r.is_if) && (d_rvalid === !r.is_if) &&
                  ((r.is_if ? if_rdata : d_rdata) === r.data), $sformatf("cont_resp%0d", k),
                  $sformatf("got irv=%b drv=%b rd=%h want irv=%b rd=%h", if_rvalid, d_rvalid,
                            r.is_if ? if_rdata : d_rdata, r.is_if, r.data));
         end
         got = (if_gnt && !d_gnt) ? OWN_IF : (d_gnt && !if_gnt) ? OWN_D : OWN_NONE;
         exp_o = exp_owner_q.pop_front();
         check(got == exp_o, $sformatf("cont_gnt%0d", k),
               $sformatf("got ig=%b dg=%b want owner %s", if_gnt, d_gnt, exp_o.name()));
         pend = if_gnt || d_gnt;
         if (if_gnt) begin
            pend_data = model(ia); resp_q.push_back('{1'b1, model(ia)}); ia += 4;
         end else if (d_gnt) begin
            pend_data = model(da); resp_q.push_back('{1'b0, model(da)}); da += 4;
         end
         @(posedge clk); #1;
      end
      chk_hold_en = 0;
      drive_idle();
      mem_rvalid = pend; mem_rdata = pend_data;
      @(negedge clk);
      if (pend) begin
         r = resp_q.pop_front();
         check((if_rvalid === r.is_if) && (d_rvalid === !r.is_if) &&
               ((r.is_if ? if_rdata : d_rdata) === r.data), "cont_drain",
               $sformatf("got irv=%b drv=%b want irv=%b rd=%h", if_rvalid, d_rvalid, r.is_if, r.data));
      end
      check((resp_q.size() == 0) && (exp_owner_q.size() == 0), "cont_queues_empty",
            $sformatf("got resp=%0d owner=%0d left want 0", resp_q.size(), exp_owner_q.size()));
      @(posedge clk); #1;
      drive_idle();
      chk_hold_en = 1;

      // reset while a data access is outstanding
      d_req = 1; d_addr = 32'h120; d_be = 4'hF; mem_gnt = 1;
      @(negedge clk);
      check(d_gnt === 1'b1, "rst_pre_gnt", $sformatf("got dg=%b want 1", d_gnt));
      @(posedge clk); #1;
      chk_hold_en = 0;
      d_req = 0; if_req = 1; if_addr = 32'h130;
      #1 arst = 1;
      #1;
      check((mem_req === 1'b0) && (if_gnt === 1'b0) && (d_gnt === 1'b0) && (dut.state_q == ARB_IDLE),
            "rst_midop", $sformatf("got req=%b ig=%b dg=%b state=%s want 0 0 0 ARB_IDLE",
                                   mem_req, if_gnt, d_gnt, dut.state_q.name()));
      @(posedge clk); #1;
      chk_rv_en = 0;
      arst = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check((if_rvalid === 1'b0) && (d_rvalid === 1'b0) && (mem_req === 1'b0), "rst_stale_rvalid",
            $sformatf("got irv=%b drv=%b req=%b want 0 0 0", if_rvalid, d_rvalid, mem_req));
      @(posedge clk); #1;
      chk_rv_en = 1; chk_hold_en = 1;
      mem_rvalid = 0; if_req = 1; if_addr = 32'h140; mem_gnt = 1;
      @(negedge clk);
      check((if_gnt === 1'b1) && (mem_addr === 32'h140), "rst_post_fetch",
            $sformatf("got ig=%b addr=%h want 1 00000140", if_gnt, mem_addr));
      @(posedge clk); #1;
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      check((if_rvalid === 1'b1) && (if_rdata === 32'h1234_5678), "rst_post_resp",
            $sformatf("got irv=%b rd=%h want 1 12345678", if_rvalid, if_rdata));
      @(posedge clk); #1;
      drive_idle();
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the instruction-fetch stage and the data load/store stage.
- The data port has priority by default. A streak counter stops fetch starvation.
- One memory transaction is outstanding at a time. A new request may issue in the same cycle the previous response returns.
- A pipeline flush cancels an in-flight fetch: the arbiter still accepts the memory response but does not pass it to the fetch stage.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory port
- DATA_WIDTH, 32, read/write data width
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while fetch waits before fetch is forced (legal range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- arst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_flush  in  1  misprediction flush from the fetch stage
- if_gnt  out  1  fetch request accepted by memory this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request; held with its fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data valid, or store acknowledge
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response valid; at least 1 cycle after mem_gnt
- mem_rdata  in  DATA_WIDTH  response data

Behaviour:
- Reset (async, arst=1):
  - state forced to ARB_IDLE; lock, discard and streak cleared.
  - mem_req, if_gnt, d_gnt, if_rvalid and d_rvalid are 0 while in reset.
  - A mem_rvalid arriving after reset with nothing outstanding is ignored.
- States:
  - ARB_IDLE: nothing outstanding.
  - ARB_WAIT_I: fetch outstanding.
  - ARB_WAIT_D: data outstanding.
- Issue window: open when state is ARB_IDLE, or when state is ARB_WAIT_* and mem_rvalid=1 (back-to-back issue).
- Selection, applied when the window opens and no lock is held:
  - Only one requester active: that requester wins.
  - Both active: data wins, unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Lock:
  - If mem_req=1 and mem_gnt=0, the selected owner is registered in lock.
  - Following cycles keep the same owner and mux, regardless of the other requester, until mem_gnt=1.
  - mem_* fields never switch mid-request.
- Memory-side outputs:
  - mem_req = issue window open and an owner exists.
  - mem_we, mem_addr, mem_wdata and mem_be are muxed from the owner.
  - For a fetch: mem_we=0 and mem_be is all ones.
- Grant: if_gnt / d_gnt = mem_req & mem_gnt & (owner matches). This is combinational, with zero latency.
- Transitions:
  - On mem_gnt, next state is ARB_WAIT_I or ARB_WAIT_D according to the owner.
  - On mem_rvalid with no new grant, next state is ARB_IDLE.
- Response routing:
  - if_rvalid = mem_rvalid & ARB_WAIT_I & ~discard & ~if_flush.
  - d_rvalid = mem_rvalid & ARB_WAIT_D.
  - Stores also return d_rvalid.
  - rdata outputs pass mem_rdata through combinationally.
- Flush:
  - if_flush=1 in ARB_WAIT_I sets discard. The outstanding response is consumed and suppressed. discard clears on that mem_rvalid.
  - if_flush during a locked, not-yet-granted fetch does not cancel it: the request issues as held and its response is discarded.
  - if_flush has no effect in ARB_IDLE or ARB_WAIT_D.
  - if_flush in the same cycle as mem_rvalid suppresses that response.
- Streak counter (width clog2(MAX_DATA_STREAK+1)):
  - Increments on each d_gnt while if_req=1, saturating at MAX_DATA_STREAK.
  - Clears on if_gnt or when if_req=0.
- Protocol assumption checks (assertions, not RTL):
  - mem_rvalid only when state is ARB_WAIT_*.
  - Requesters never drop req before gnt.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - typedef enum arb_state_e {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D}
  - typedef enum owner_e {OWN_NONE, OWN_IF, OWN_D}
  - struct types grouping the request fields for each port
- No sub-module. The streak counter and the owner mux stay inline.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; memory grants immediately, rvalid 2 cycles later with 0x00500093 -> if_gnt in cycle 0, if_rvalid=1 with if_rdata=0x00500093 in cycle 2; next fetch 0x104 issues in that same cycle.
- Contention with MAX_DATA_STREAK=4: if_req and d_req held continuously, 1-cycle memory -> d_gnt 4 times, then if_gnt once, then the pattern repeats.
- Lock: data selected, mem_gnt=0 for 3 cycles while if_req rises -> mem_addr stays at d_addr for all 3 cycles; d_gnt fires on the 4th cycle; no if_gnt during the lock.
- Flush: fetch of 0x200 granted; if_flush=1 one cycle later; rvalid 3 cycles after grant -> if_rvalid stays 0; state returns to ARB_IDLE; the next fetch at 0x400 is delivered normally.
- Store ack: d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 and mem_be=0011 on issue; d_rvalid=1 with the memory ack.
- Reset mid-operation: arst asserted in ARB_WAIT_D -> mem_req=0 immediately and state is ARB_IDLE; a stale mem_rvalid after release produces no d_rvalid and no if_rvalid.
